// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped down-counter: register offsets,
// CTRL field positions, mode encodings and FSM state encodings.
package timer_counter_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_counter_prescaler.sv
// Tick generator: pulses tick once every PRESCALE cycles of run, restarting
// from zero whenever clear is asserted.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tick = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_counter.sv
// Memory-mapped down-counter with one-shot / auto-reload modes and a masked IRQ.
// Define TIMER_PRESCALE_EN to slow the count rate by PRESCALE clk cycles per decrement.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irqPending_q, irqPending_d;

  logic       en;
  logic [1:0] mode;
  logic       tick;

  assign en   = ctrl_q[CTRL_EN];
  assign mode = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];

`ifdef TIMER_PRESCALE_EN
  logic prescaleClear;
  logic prescaleRun;

  assign prescaleClear = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign prescaleRun   = (state_q == ST_CNT) && en;

  timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(prescaleClear),
    .run  (prescaleRun),
    .tick (tick)
  );
`else
  logic unusedPrescale;
  assign unusedPrescale = |PRESCALE;
  assign tick = 1'b1;
`endif

  // FSM first; the CPU write is applied afterwards so it overrides the INT-state EN clear.
  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    preset_d     = preset_q;
    count_d      = count_q;
    irqPending_d = irqPending_q;

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = en ? ST_CNT : ST_IDLE;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d      = '0;
            irqPending_d = 1'b1;
            state_d      = ST_INT;
          end
        end
      end
      ST_INT: begin
        case (mode)
          MODE_RELOAD: begin
            irqPending_d = 1'b0;
            state_d      = ST_LOAD;
          end
          MODE_ONESHOT: begin
            ctrl_d[CTRL_EN] = 1'b0;
            state_d         = ST_IDLE;
          end
          default: begin
            ctrl_d[CTRL_EN] = 1'b0;
            state_d         = ST_IDLE;
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase

    if (We) begin
      case (Addr)
        ADDR_CTRL: begin
          ctrl_d       = Din[3:0];
          irqPending_d = 1'b0;
        end
        ADDR_PRESET: preset_d = Din;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ctrl_q       <= '0;
      preset_q     <= '0;
      count_q      <= '0;
      irqPending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      preset_q     <= preset_d;
      count_q      <= count_d;
      irqPending_q <= irqPending_d;
    end
  end

  always_comb begin
    case (Addr)
      ADDR_CTRL:   Dout = {28'd0, ctrl_q};
      ADDR_PRESET: Dout = preset_q;
      ADDR_COUNT:  Dout = count_q;
      default:     Dout = '0;
    endcase
  end

  assign IRQ = ctrl_q[CTRL_IM] & irqPending_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter; the prescaler scenario runs
// only when TIMER_PRESCALE_EN is defined.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  Addr;
  logic        We;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int checks;
  int failures;

  timer_counter #(
    .PRESCALE(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .We   (We),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every task leaves the bench 1 ns after a rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    We   = 1'b1;
    stepCycle();
    We   = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    We    = 1'b0;
    stepCycle();
    stepCycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    for (int a = 0; a < 3; a++) begin
      Addr = 2'(a);
      #1;
      checks++;
      if (Dout !== 32'd0) begin
        failures++;
        $display("[TB] FAIL reset_dout addr=%0d got=%h want=0", a, Dout);
      end
    end
    checks++;
    if (IRQ !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_irq got=%b want=0", IRQ);
    end
  endtask

  task automatic test_oneshot();
    doReset();
    writeReg(2'd1, 32'd5);
    writeReg(2'd0, 32'h9);
    Addr = 2'd2;
    stepCycle();
    stepCycle();
    for (int k = 0; k <= 5; k++) begin
      checks++;
      if (Dout !== 32'(5 - k)) begin
        failures++;
        $display("[TB] FAIL oneshot_count k=%0d got=%0d want=%0d", k, Dout, 5 - k);
      end
      checks++;
      if (IRQ !== (k == 5)) begin
        failures++;
        $display("[TB] FAIL oneshot_irq k=%0d got=%b want=%b", k, IRQ, k == 5);
      end
      stepCycle();
    end
    stepCycle();
    Addr = 2'd0;
    #1;
    checks++;
    if (Dout !== 32'h8) begin
      failures++;
      $display("[TB] FAIL oneshot_en_clear got=%h want=8", Dout);
    end
    checks++;
    if (IRQ !== 1'b1) begin
      failures++;
      $display("[TB] FAIL oneshot_irq_held got=%b want=1", IRQ);
    end
    writeReg(2'd0, 32'h0);
    checks++;
    if (IRQ !== 1'b0) begin
      failures++;
      $display("[TB] FAIL oneshot_irq_clear got=%b want=0", IRQ);
    end
  endtask

  task automatic test_reload();
    logic [31:0] wantCount;
    logic        wantIrq;
    doReset();
    writeReg(2'd1, 32'd3);
    writeReg(2'd0, 32'hB);
    Addr = 2'd2;
    for (int c = 1; c <= 16; c++) begin
      stepCycle();
      if (c < 2) begin
        wantCount = 32'd0;
      end else begin
        case ((c - 2) % 5)
          0:       wantCount = 32'd3;
          1:       wantCount = 32'd2;
          2:       wantCount = 32'd1;
          default: wantCount = 32'd0;
        endcase
      end
      wantIrq = (c >= 5) && ((c - 5) % 5 == 0);
      checks++;
      if (Dout !== wantCount) begin
        failures++;
        $display("[TB] FAIL reload_count c=%0d got=%0d want=%0d", c, Dout, wantCount);
      end
      checks++;
      if (IRQ !== wantIrq) begin
        failures++;
        $display("[TB] FAIL reload_irq c=%0d got=%b want=%b", c, IRQ, wantIrq);
      end
    end
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    for (int a = 0; a < 3; a++) begin
      Addr = 2'(a);
      #1;
      checks++;
      if (Dout !== 32'd0) begin
        failures++;
        $display("[TB] FAIL midrun_reset addr=%0d got=%h want=0", a, Dout);
      end
    end
  endtask

  task automatic test_midcount();
    bit found;
    doReset();
    writeReg(2'd1, 32'd100);
    writeReg(2'd0, 32'h1);
    Addr  = 2'd2;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      stepCycle();
      if (Dout == 32'd50) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL midcount_reach50 got=%0d want=50", Dout);
    end
    writeReg(2'd1, 32'd2);
    Addr = 2'd2;
    #1;
    checks++;
    if (Dout !== 32'd49) begin
      failures++;
      $display("[TB] FAIL midcount_continue got=%0d want=49", Dout);
    end
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (Dout == 32'd40) found = 1'b1;
      else stepCycle();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL midcount_reach40 got=%0d want=40", Dout);
    end
    writeReg(2'd0, 32'h0);
    Addr = 2'd2;
    for (int i = 0; i < 4; i++) stepCycle();
    checks++;
    if (Dout !== 32'd39) begin
      failures++;
      $display("[TB] FAIL midcount_freeze got=%0d want=39", Dout);
    end
    checks++;
    if (IRQ !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midcount_irq got=%b want=0", IRQ);
    end
  endtask

  task automatic test_int_collision();
    doReset();
    writeReg(2'd1, 32'd2);
    writeReg(2'd0, 32'h1);
    for (int i = 0; i < 5; i++) stepCycle();
    Addr = 2'd0;
    #1;
    checks++;
    if (Dout !== 32'h0) begin
      failures++;
      $display("[TB] FAIL masked_en_clear got=%h want=0", Dout);
    end
    checks++;
    if (IRQ !== 1'b0) begin
      failures++;
      $display("[TB] FAIL masked_irq got=%b want=0", IRQ);
    end
    writeReg(2'd0, 32'h1);
    for (int i = 0; i < 4; i++) stepCycle();
    writeReg(2'd0, 32'h9);
    Addr = 2'd0;
    #1;
    checks++;
    if (Dout !== 32'h9) begin
      failures++;
      $display("[TB] FAIL collision_cpu_wins got=%h want=9", Dout);
    end
    stepCycle();
    stepCycle();
    Addr = 2'd2;
    #1;
    checks++;
    if (Dout !== 32'd2) begin
      failures++;
      $display("[TB] FAIL collision_restart got=%0d want=2", Dout);
    end
    stepCycle();
    stepCycle();
    checks++;
    if (IRQ !== 1'b1) begin
      failures++;
      $display("[TB] FAIL collision_irq got=%b want=1", IRQ);
    end
  endtask

`ifdef TIMER_PRESCALE_EN
  task automatic test_prescale();
    logic wantIrq;
    doReset();
    writeReg(2'd1, 32'd2);
    writeReg(2'd0, 32'hB);
    Addr = 2'd2;
    for (int c = 1; c <= 22; c++) begin
      stepCycle();
      wantIrq = (c % 10 == 0);
      checks++;
      if (IRQ !== wantIrq) begin
        failures++;
        $display("[TB] FAIL prescale_irq c=%0d got=%b want=%b", c, IRQ, wantIrq);
      end
    end
    checks++;
    if (Dout !== 32'd2) begin
      failures++;
      $display("[TB] FAIL prescale_count got=%0d want=2", Dout);
    end
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    for (int a = 0; a < 3; a++) begin
      Addr = 2'(a);
      #1;
      checks++;
      if (Dout !== 32'd0) begin
        failures++;
        $display("[TB] FAIL prescale_reset addr=%0d got=%h want=0", a, Dout);
      end
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    Addr     = 2'd0;
    We       = 1'b0;
    Din      = 32'd0;
    test_reset();
    test_oneshot();
    test_reload();
    test_midcount();
    test_int_collision();
`ifdef TIMER_PRESCALE_EN
    test_prescale();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
